// File: rtl/ps2_host_tx_queue.sv
// ps2_host_tx_queue: PS/2 host-to-device transmitter fronted by a DEPTH-entry byte queue.
// Each queued byte is sent with the full request-to-send sequence (clock inhibit, start
// request, 8 data bits LSB first, odd parity, stop, device ACK), guarded by a per-byte
// timeout. Failures pulse ERROR with a code and drop the head byte.
// Optional macro PS2_TX_RETRY_EN: a failed byte is re-attempted up to MAX_RETRIES times
// before ERROR is raised.
module ps2_host_tx_queue #(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned MAX_RETRIES    = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLK_MOUSE_IN,
  output logic       CLK_MOUSE_OUT_EN,
  input  logic       DATA_MOUSE_IN,
  output logic       DATA_MOUSE_OUT,
  output logic       DATA_MOUSE_OUT_EN,
  input  logic       SEND_BYTE,
  input  logic [7:0] BYTE_TO_SEND,
  output logic       QUEUE_FULL,
  output logic       QUEUE_EMPTY,
  output logic       BYTE_SENT,
  output logic       OVERFLOW,
  output logic       ERROR,
  output logic [1:0] ERROR_CODE
);

  localparam int unsigned IW = $clog2(INHIBIT_CYCLES) + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int unsigned RW = $clog2(MAX_RETRIES) + 1;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_START, S_DATA, S_PARITY, S_STOP, S_ACK, S_REL
  } state_t;

  logic          clk_meta_q, clk_sync_q, clk_prev_q;
  logic          data_meta_q, data_sync_q;
  logic          fe;

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  state_t        state_q, state_d;
  logic [7:0]    byte_q, byte_d;
  logic [2:0]    idx_q, idx_d;
  logic [IW-1:0] inh_q, inh_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          clk_oe_q, clk_oe_d, data_oe_q, data_oe_d, data_out_q, data_out_d;
  logic          byte_sent_q, byte_sent_d, overflow_q, overflow_d, error_q, error_d;
  logic [1:0]    err_code_q, err_code_d;

  logic          full, push, pop, fail, retry_ok, in_xfer, tmo_hit;
  logic [1:0]    fail_code;

  assign fe                = clk_prev_q & ~clk_sync_q;
  assign full              = (count_q == CW'(DEPTH));
  assign QUEUE_FULL        = full;
  assign QUEUE_EMPTY       = (count_q == '0) && (state_q == S_IDLE);
  assign CLK_MOUSE_OUT_EN  = clk_oe_q;
  assign DATA_MOUSE_OUT    = data_out_q;
  assign DATA_MOUSE_OUT_EN = data_oe_q;
  assign BYTE_SENT         = byte_sent_q;
  assign OVERFLOW          = overflow_q;
  assign ERROR             = error_q;
  assign ERROR_CODE        = err_code_q;

  // Next-state for the transfer FSM and the byte queue; failures are resolved after the
  // per-state logic so no-ACK takes priority over a coincident timeout and overrides a
  // same-cycle release.
  always_comb begin
    state_d     = state_q;
    byte_d      = byte_q;
    idx_d       = idx_q;
    inh_d       = inh_q;
    tmo_d       = tmo_q;
    retry_d     = retry_q;
    clk_oe_d    = clk_oe_q;
    data_oe_d   = data_oe_q;
    data_out_d  = data_out_q;
    byte_sent_d = 1'b0;
    error_d     = 1'b0;
    err_code_d  = '0;
    overflow_d  = SEND_BYTE & full;
    push        = SEND_BYTE & ~full;
    pop         = 1'b0;
    fail        = 1'b0;
    fail_code   = '0;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
`ifdef PS2_TX_RETRY_EN
    retry_ok    = (retry_q < RW'(MAX_RETRIES));
`else
    retry_ok    = 1'b0;
`endif
    in_xfer     = (state_q != S_IDLE) && (state_q != S_INHIBIT);
    tmo_hit     = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    if (in_xfer) tmo_d = tmo_q + TW'(1);

    case (state_q)
      S_IDLE: begin
        clk_oe_d   = 1'b0;
        data_oe_d  = 1'b0;
        data_out_d = 1'b0;
        if (count_q != '0) begin
          byte_d   = mem_q[rd_ptr_q];
          inh_d    = '0;
          tmo_d    = '0;
          retry_d  = '0;
          clk_oe_d = 1'b1;
          state_d  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (inh_q == IW'(INHIBIT_CYCLES - 1)) begin
          clk_oe_d   = 1'b0;
          data_oe_d  = 1'b1;
          data_out_d = 1'b0;
          tmo_d      = '0;
          state_d    = S_REQ;
        end else begin
          inh_d = inh_q + IW'(1);
        end
      end
      S_REQ: state_d = S_START;
      S_START: begin
        if (fe) begin
          idx_d      = '0;
          data_out_d = byte_q[0];
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        if (fe) begin
          if (idx_q == 3'd7) begin
            data_out_d = ~^byte_q;
            state_d    = S_PARITY;
          end else begin
            idx_d      = idx_q + 3'd1;
            data_out_d = byte_q[idx_d];
          end
        end
      end
      S_PARITY: begin
        if (fe) begin
          data_oe_d  = 1'b0;
          data_out_d = 1'b0;
          state_d    = S_STOP;
        end
      end
      S_STOP: if (fe) state_d = S_ACK;
      S_ACK: begin
        if (fe) begin
          if (data_sync_q) begin
            fail      = 1'b1;
            fail_code = 2'b10;
          end else begin
            state_d = S_REL;
          end
        end
      end
      S_REL: begin
        if (clk_sync_q && data_sync_q) begin
          byte_sent_d = 1'b1;
          pop         = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (in_xfer && tmo_hit && !fail) begin
      fail      = 1'b1;
      fail_code = 2'b01;
    end

    if (fail) begin
      byte_sent_d = 1'b0;
      data_oe_d   = 1'b0;
      data_out_d  = 1'b0;
      if (retry_ok) begin
        retry_d  = retry_q + RW'(1);
        inh_d    = '0;
        clk_oe_d = 1'b1;
        pop      = 1'b0;
        state_d  = S_INHIBIT;
      end else begin
        error_d    = 1'b1;
        err_code_d = fail_code;
        clk_oe_d   = 1'b0;
        pop        = 1'b1;
        state_d    = S_IDLE;
      end
    end

    if (push) begin
      mem_d[wr_ptr_q] = BYTE_TO_SEND;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // All state: pad synchronisers, queue storage and FSM with registered outputs.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      byte_q      <= '0;
      idx_q       <= '0;
      inh_q       <= '0;
      tmo_q       <= '0;
      retry_q     <= '0;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      data_out_q  <= 1'b0;
      byte_sent_q <= 1'b0;
      overflow_q  <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= '0;
    end else begin
      clk_meta_q  <= CLK_MOUSE_IN;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= DATA_MOUSE_IN;
      data_sync_q <= data_meta_q;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      byte_q      <= byte_d;
      idx_q       <= idx_d;
      inh_q       <= inh_d;
      tmo_q       <= tmo_d;
      retry_q     <= retry_d;
      clk_oe_q    <= clk_oe_d;
      data_oe_q   <= data_oe_d;
      data_out_q  <= data_out_d;
      byte_sent_q <= byte_sent_d;
      overflow_q  <= overflow_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx_queue.sv
// tb_ps2_host_tx_queue: scoreboard bench with a PS/2 device model driving the open-collector lines.
`timescale 1ns/1ps
module tb_ps2_host_tx_queue;
  localparam int unsigned INH = 100;
  localparam int unsigned TMO = 5000;
  localparam int          H   = 20;
`ifdef PS2_TX_RETRY_EN
  localparam int unsigned ATT = 3;
`else
  localparam int unsigned ATT = 1;
`endif

  typedef struct {
    logic        is_err;
    logic [1:0]  code;
    logic [10:0] frame;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       CLK_MOUSE_OUT_EN, DATA_MOUSE_OUT, DATA_MOUSE_OUT_EN;
  logic       SEND_BYTE = 1'b0;
  logic [7:0] BYTE_TO_SEND = '0;
  logic       QUEUE_FULL, QUEUE_EMPTY, BYTE_SENT, OVERFLOW, ERROR;
  logic [1:0] ERROR_CODE;
  logic       dev_clk = 1'b1, dev_data = 1'b1;
  logic       clk_line, data_line;

  assign clk_line  = ~CLK_MOUSE_OUT_EN & dev_clk;
  assign data_line = (DATA_MOUSE_OUT_EN ? DATA_MOUSE_OUT : 1'b1) & dev_data;

  ps2_host_tx_queue #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .DEPTH(4),
    .MAX_RETRIES(2)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .CLK_MOUSE_IN(clk_line), .CLK_MOUSE_OUT_EN(CLK_MOUSE_OUT_EN),
    .DATA_MOUSE_IN(data_line), .DATA_MOUSE_OUT(DATA_MOUSE_OUT),
    .DATA_MOUSE_OUT_EN(DATA_MOUSE_OUT_EN),
    .SEND_BYTE(SEND_BYTE), .BYTE_TO_SEND(BYTE_TO_SEND),
    .QUEUE_FULL(QUEUE_FULL), .QUEUE_EMPTY(QUEUE_EMPTY),
    .BYTE_SENT(BYTE_SENT), .OVERFLOW(OVERFLOW),
    .ERROR(ERROR), .ERROR_CODE(ERROR_CODE)
  );

  always #5 CLK = ~CLK;

  exp_t        exp_q[$];
  logic [10:0] frame_q[$];
  int unsigned checks = 0, passed = 0;
  int unsigned cyc = 0, req_cyc = 0;
  int unsigned sent_cnt = 0, err_cnt = 0, ovf_cnt = 0, req_cnt = 0;
  int unsigned inh_run = 0, ignore_cnt = 0, nack_cnt = 0;
  int          dev_pulse = 0;
  logic        req_pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Request detector: measures the clock-inhibit length and flags a host request.
  always @(posedge CLK) begin
    #1;
    if (CLK_MOUSE_OUT_EN) inh_run++;
    else begin
      if (inh_run != 0 && DATA_MOUSE_OUT_EN && !DATA_MOUSE_OUT) begin
        req_cnt++;
        req_pend = 1'b1;
        chk("inhibit_len", 32'(inh_run), 32'(INH));
      end
      inh_run = 0;
    end
  end

  // Device side of one frame: 12 clock pulses, sampling data at the end of each low phase.
  task automatic dev_xfer(input logic do_ack);
    logic [10:0] fr;
    fr = '0;
    dev_pulse = 0;
    repeat (H) @(negedge CLK);
    fr[0] = data_line;
    for (int p = 1; p <= 12; p++) begin
      dev_pulse = p;
      if (p == 12 && do_ack) begin
        dev_data = 1'b0;
        repeat (4) @(negedge CLK);
      end
      dev_clk = 1'b0;
      repeat (H) @(negedge CLK);
      if (p <= 10) fr[p] = data_line;
      dev_clk = 1'b1;
      repeat (H) @(negedge CLK);
    end
    dev_data = 1'b1;
    if (do_ack) frame_q.push_back(fr);
  endtask

  // Device model: ignores, NACKs or ACKs each request according to the stimulus counters.
  initial begin : device
    forever begin
      @(negedge CLK);
      if (req_pend) begin
        req_pend = 1'b0;
        if (ignore_cnt > 0) ignore_cnt--;
        else if (nack_cnt > 0) begin
          nack_cnt--;
          dev_xfer(1'b0);
        end else dev_xfer(1'b1);
      end
    end
  end

  // Monitor: pops the scoreboard whenever BYTE_SENT or ERROR is presented.
  initial begin : monitor
    exp_t        e;
    logic [10:0] f;
    logic        prev_doe;
    prev_doe = 1'b0;
    forever begin
      @(negedge CLK);
      cyc++;
      if (DATA_MOUSE_OUT_EN && !prev_doe) req_cyc = cyc;
      prev_doe = DATA_MOUSE_OUT_EN;
      if (OVERFLOW) ovf_cnt++;
      if (BYTE_SENT) sent_cnt++;
      if (ERROR) err_cnt++;
      if (BYTE_SENT || ERROR) begin
        chk("event_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("event_kind", 32'({BYTE_SENT, ERROR}), e.is_err ? 32'd1 : 32'd2);
          if (e.is_err) begin
            chk("error_code", 32'(ERROR_CODE), 32'(e.code));
            chk("err_clk_oe", 32'(CLK_MOUSE_OUT_EN), 32'd0);
            chk("err_data_oe", 32'(DATA_MOUSE_OUT_EN), 32'd0);
            if (e.code == 2'b01) chk("timeout_latency", cyc - req_cyc, 32'(TMO));
          end else begin
            chk("frame_count", 32'(frame_q.size()), 32'd1);
            if (frame_q.size() != 0) begin
              f = frame_q.pop_front();
              chk("frame_bits", 32'(f), 32'(e.frame));
            end
          end
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    BYTE_TO_SEND = b;
    SEND_BYTE = 1'b1;
    @(negedge CLK);
    SEND_BYTE = 1'b0;
  endtask

  task automatic expect_ack(input logic [10:0] fr);
    exp_q.push_back('{is_err: 1'b0, code: 2'b00, frame: fr});
  endtask

  task automatic expect_err(input logic [1:0] code);
    exp_q.push_back('{is_err: 1'b1, code: code, frame: 11'd0});
  endtask

  task automatic wait_done(input int unsigned bound);
    int unsigned n;
    n = 0;
    while ((exp_q.size() != 0 || !QUEUE_EMPTY) && n < bound) begin
      @(negedge CLK);
      n++;
    end
    chk("drain_in_time", 32'(n < bound), 32'd1);
  endtask

  // Directed stimulus; frames are {stop, odd parity, byte, start}.
  initial begin : stim
    int unsigned s0, e0, r0, n;
    logic [10:0] ovf_frames [4];
    ovf_frames = '{{1'b1, 1'b0, 8'h01, 1'b0}, {1'b1, 1'b0, 8'h02, 1'b0},
                   {1'b1, 1'b1, 8'h03, 1'b0}, {1'b1, 1'b0, 8'h04, 1'b0}};
    repeat (3) @(negedge CLK);
    chk("rst_clk_oe", 32'(CLK_MOUSE_OUT_EN), 32'd0);
    chk("rst_data_oe", 32'(DATA_MOUSE_OUT_EN), 32'd0);
    chk("rst_data_out", 32'(DATA_MOUSE_OUT), 32'd0);
    chk("rst_flags", 32'({QUEUE_FULL, QUEUE_EMPTY, BYTE_SENT, OVERFLOW, ERROR, ERROR_CODE}),
        32'b0100000);
    RESET = 1'b1;
    @(negedge CLK);

    // Single byte 0xF4: start 0, 0010_1111 LSB first, parity 0, stop 1.
    s0 = sent_cnt;
    expect_ack({1'b1, 1'b0, 8'hF4, 1'b0});
    push_byte(8'hF4);
    wait_done(5000);
    chk("f4_sent_once", sent_cnt - s0, 32'd1);
    chk("f4_queue_empty", 32'(QUEUE_EMPTY), 32'd1);

    // Three back-to-back pushes, sent in order.
    s0 = sent_cnt; e0 = err_cnt;
    expect_ack({1'b1, 1'b1, 8'hFF, 1'b0});
    expect_ack({1'b1, 1'b1, 8'hF3, 1'b0});
    expect_ack({1'b1, 1'b0, 8'h64, 1'b0});
    push_byte(8'hFF);
    push_byte(8'hF3);
    push_byte(8'h64);
    wait_done(10000);
    chk("burst_sent", sent_cnt - s0, 32'd3);
    chk("burst_no_error", err_cnt - e0, 32'd0);

    // Five pushes into a 4-entry queue before the device has clocked anything.
    s0 = sent_cnt;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) expect_ack(ovf_frames[i]);
      BYTE_TO_SEND = 8'(i + 1);
      SEND_BYTE = 1'b1;
      @(negedge CLK);
      if (i == 3) begin
        chk("full_after_4", 32'(QUEUE_FULL), 32'd1);
        chk("no_ovf_at_4", 32'(OVERFLOW), 32'd0);
      end
      if (i == 4) begin
        chk("ovf_pulse", 32'(OVERFLOW), 32'd1);
        chk("full_at_5", 32'(QUEUE_FULL), 32'd1);
      end
    end
    SEND_BYTE = 1'b0;
    @(negedge CLK);
    chk("ovf_one_cycle", 32'(OVERFLOW), 32'd0);
    wait_done(10000);
    chk("ovf_drained", sent_cnt - s0, 32'd4);
    chk("ovf_count", ovf_cnt, 32'd1);

    // Device never clocks for the first byte: timeout, then the next byte goes out.
    s0 = sent_cnt; e0 = err_cnt; r0 = req_cnt;
    ignore_cnt = ATT;
    expect_err(2'b01);
    expect_ack({1'b1, 1'b1, 8'h55, 1'b0});
    push_byte(8'hAA);
    push_byte(8'h55);
    wait_done(30000);
    chk("tmo_err_count", err_cnt - e0, 32'd1);
    chk("tmo_next_sent", sent_cnt - s0, 32'd1);
    chk("tmo_attempts", req_cnt - r0, 32'(ATT + 1));

    // Device holds DATA high at the ACK clock.
    e0 = err_cnt; r0 = req_cnt;
    nack_cnt = ATT;
    expect_err(2'b10);
    push_byte(8'h12);
    wait_done(10000);
    chk("nack_err_count", err_cnt - e0, 32'd1);
    chk("nack_attempts", req_cnt - r0, 32'(ATT));

    // Reset while data bit 3 of 0xC3 (a 0) is on the line.
    s0 = sent_cnt; e0 = err_cnt;
    push_byte(8'hC3);
    n = 0;
    while (dev_pulse != 4 && n < 5000) begin
      @(negedge CLK);
      n++;
    end
    chk("reach_bit3", 32'(n < 5000), 32'd1);
    repeat (10) @(negedge CLK);
    chk("bit3_driven", 32'({DATA_MOUSE_OUT_EN, DATA_MOUSE_OUT}), 32'b10);
    RESET = 1'b0;
    @(negedge CLK);
    chk("midrst_clk_oe", 32'(CLK_MOUSE_OUT_EN), 32'd0);
    chk("midrst_data_oe", 32'(DATA_MOUSE_OUT_EN), 32'd0);
    chk("midrst_empty", 32'(QUEUE_EMPTY), 32'd1);
    RESET = 1'b1;
    repeat (1000) @(negedge CLK);
    chk("midrst_no_sent", sent_cnt - s0, 32'd0);
    chk("midrst_no_err", err_cnt - e0, 32'd0);
    chk("midrst_idle", 32'({QUEUE_EMPTY, CLK_MOUSE_OUT_EN, DATA_MOUSE_OUT_EN}), 32'b100);
    frame_q.delete();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed so far", passed, checks);
    $fatal(1, "watchdog");
  end

endmodule
